branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit.sv | 191 +++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolution for an issue bundle of LANES branches.
// Stage 1 evaluates each lane's condition; stage 2 picks the first
// mispredicted lane and builds the redirect/squash information.

// Per-lane branch condition evaluator (purely combinational).
module bru_lane_cmp #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       rt,
    input  logic [2:0]       mode,
    input  logic             en,
    output logic             taken
);
    logic a_neg;
    logic a_zero;
    logic hit;

    assign a_neg  = a[WIDTH-1];
    assign a_zero = (a == '0);

    // Signed compares against zero reduce to sign bit and zero detect.
    always_comb begin
        hit = 1'b0;
        case (mode)
            3'b000:  hit = (a == b);
            3'b001:  hit = (a != b);
            3'b010:  hit = !a_neg && !a_zero;
            3'b011:  hit = a_neg || a_zero;
            3'b100:  hit = (rt == 5'd0) ? a_neg : !a_neg;
            3'b101:  hit = 1'b1;
            default: hit = 1'b0;
        endcase
        taken = en & hit;
    end
endmodule

module branch_resolve_unit #(
    parameter  int LANES = 4,
    parameter  int WIDTH = 32,
    parameter  int CNTW  = 16,
    localparam int IDXW  = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES-1:0]       lane_en,
    input  logic [LANES*WIDTH-1:0] op_a,
    input  logic [LANES*WIDTH-1:0] op_b,
    input  logic [LANES*5-1:0]     rt,
    input  logic [LANES*3-1:0]     mode,
    input  logic [LANES-1:0]       pred_taken,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES-1:0]       taken,
    output logic                   mispredict,
    output logic [IDXW-1:0]        redirect_idx,
    output logic [LANES-1:0]       squash_mask,
    output logic [CNTW-1:0]        mispredict_count
);
    logic [LANES-1:0] lane_taken;

    logic             s1_valid_q, s1_valid_d;
    logic [LANES-1:0] s1_en_q, s1_en_d;
    logic [LANES-1:0] s1_pred_q, s1_pred_d;
    logic [LANES-1:0] s1_taken_q, s1_taken_d;

    logic             out_valid_q, out_valid_d;
    logic [LANES-1:0] taken_q, taken_d;
    logic             mispredict_q, mispredict_d;
    logic [IDXW-1:0]  redirect_idx_q, redirect_idx_d;
    logic [LANES-1:0] squash_mask_q, squash_mask_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic             s2_free, s1_adv, accept;
    logic [LANES-1:0] mm;
    logic             res_misp;
    logic [IDXW-1:0]  res_idx;
    logic [LANES-1:0] res_sq;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        bru_lane_cmp #(.WIDTH(WIDTH)) u_cmp (
            .a     (op_a[g*WIDTH +: WIDTH]),
            .b     (op_b[g*WIDTH +: WIDTH]),
            .rt    (rt[g*5 +: 5]),
            .mode  (mode[g*3 +: 3]),
            .en    (lane_en[g]),
            .taken (lane_taken[g])
        );
    end

    // Handshake: in_ready depends only on state and out_ready, never on in_valid.
    always_comb begin
        s2_free  = !out_valid_q | out_ready;
        s1_adv   = s1_valid_q & s2_free;
        in_ready = !s1_valid_q | s2_free;
        accept   = in_valid & in_ready & !flush;
    end

    // Resolve stage-1 contents: lowest mismatching lane wins, squash everything above it.
    always_comb begin
        mm       = s1_en_q & (s1_taken_q ^ s1_pred_q);
        res_misp = |mm;
        res_idx  = '0;
        res_sq   = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mm[i]) res_idx = IDXW'(i);
        end
        for (int i = 0; i < LANES; i++) begin
            res_sq[i] = res_misp && (i > int'(res_idx));
        end
    end

    // Stage-1 next state: flush wins over a same-cycle accept.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_en_d    = s1_en_q;
        s1_pred_d  = s1_pred_q;
        s1_taken_d = s1_taken_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (accept) begin
            s1_valid_d = 1'b1;
            s1_en_d    = lane_en;
            s1_pred_d  = pred_taken;
            s1_taken_d = lane_taken;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage-2 next state and counter; a bundle killed by flush is not counted.
    always_comb begin
        out_valid_d    = out_valid_q;
        taken_d        = taken_q;
        mispredict_d   = mispredict_q;
        redirect_idx_d = redirect_idx_q;
        squash_mask_d  = squash_mask_q;
        cnt_d          = cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (s1_adv) begin
            out_valid_d    = 1'b1;
            taken_d        = s1_taken_q;
            mispredict_d   = res_misp;
            redirect_idx_d = res_idx;
            squash_mask_d  = res_sq;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (out_valid_q && out_ready && mispredict_q && !flush && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q     <= 1'b0;
            s1_en_q        <= '0;
            s1_pred_q      <= '0;
            s1_taken_q     <= '0;
            out_valid_q    <= 1'b0;
            taken_q        <= '0;
            mispredict_q   <= 1'b0;
            redirect_idx_q <= '0;
            squash_mask_q  <= '0;
            cnt_q          <= '0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_en_q        <= s1_en_d;
            s1_pred_q      <= s1_pred_d;
            s1_taken_q     <= s1_taken_d;
            out_valid_q    <= out_valid_d;
            taken_q        <= taken_d;
            mispredict_q   <= mispredict_d;
            redirect_idx_q <= redirect_idx_d;
            squash_mask_q  <= squash_mask_d;
            cnt_q          <= cnt_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign taken            = taken_q;
    assign mispredict       = mispredict_q;
    assign redirect_idx     = redirect_idx_q;
    assign squash_mask      = squash_mask_q;
    assign mispredict_count = cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed table, hand sequences for
// back-pressure / flush / saturation / async reset, then random traffic
// checked by an in-order scoreboard built from the branch rules.
module tb_branch_resolve_unit;
    localparam int LANES = 4;
    localparam int WIDTH = 32;
    localparam int CNTW  = 4;
    localparam int IDXW  = 2;

    logic                   clk = 1'b0;
    logic                   resetn = 1'b1;
    logic                   flush = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [LANES-1:0]       lane_en = '0;
    logic [LANES*WIDTH-1:0] op_a = '0;
    logic [LANES*WIDTH-1:0] op_b = '0;
    logic [LANES*5-1:0]     rt = '0;
    logic [LANES*3-1:0]     mode = '0;
    logic [LANES-1:0]       pred_taken = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [LANES-1:0]       taken;
    logic                   mispredict;
    logic [IDXW-1:0]        redirect_idx;
    logic [LANES-1:0]       squash_mask;
    logic [CNTW-1:0]        mispredict_count;

    branch_resolve_unit #(.LANES(LANES), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .lane_en(lane_en), .op_a(op_a), .op_b(op_b), .rt(rt), .mode(mode),
        .pred_taken(pred_taken),
        .out_valid(out_valid), .out_ready(out_ready),
        .taken(taken), .mispredict(mispredict), .redirect_idx(redirect_idx),
        .squash_mask(squash_mask), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] tk;
        logic       mp;
        logic [1:0] idx;
        logic [3:0] sq;
    } res_t;

    typedef struct packed {
        logic [3:0]       en;
        logic [3:0]       pred;
        logic [3:0][2:0]  md;
        logic [3:0][31:0] a;
        logic [3:0][31:0] b;
        logic [3:0][4:0]  r;
        res_t             exp;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_deliv = 0;
    int   cnt_m = 0;
    res_t exp_q[$];
    logic hold_prev = 1'b0;
    logic [11:0] prev_out = '0;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Branch condition from the mode rules, using wide signed arithmetic.
    function automatic logic lane_ref(input logic [2:0] m, input logic [31:0] a,
                                      input logic [31:0] b, input logic [4:0] r);
        longint sa;
        sa = longint'($signed(a));
        case (m)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd2: return sa > 0;
            3'd3: return sa <= 0;
            3'd4: return (r == 0) ? (sa < 0) : (sa >= 0);
            3'd5: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic res_t ref_bundle();
        res_t res;
        bit   found;
        int   m;
        res = '0;
        found = 0;
        for (int l = 0; l < LANES; l++) begin
            res.tk[l] = lane_en[l] && lane_ref(mode[l*3 +: 3], op_a[l*32 +: 32],
                                               op_b[l*32 +: 32], rt[l*5 +: 5]);
            if (!found && lane_en[l] && (res.tk[l] != pred_taken[l])) begin
                found = 1;
                res.mp = 1'b1;
                res.idx = 2'(l);
            end
        end
        if (found) begin
            m = 15 & ~((2 << int'(res.idx)) - 1);
            res.sq = 4'(m);
        end
        return res;
    endfunction

    // Scoreboard step, sampled on the falling edge before the next rising edge.
    task automatic mon();
        res_t e;
        if (!resetn) return;
        if (hold_prev)
            chk("hold_stable", {out_valid, taken, mispredict, redirect_idx, squash_mask}, prev_out);
        chk("in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
        if (exp_q.size() == 0) chk("idle_out_valid", out_valid, 0);
        chk("count", mispredict_count, cnt_m);
        if (out_valid && out_ready && !flush) begin
            chk("deliver_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("deliver", {taken, mispredict, redirect_idx, squash_mask}, e);
                if (e.mp && cnt_m < (1 << CNTW) - 1) cnt_m++;
                n_deliv++;
            end
        end
        if (flush) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back(ref_bundle());
        hold_prev = out_valid && !out_ready && !flush;
        prev_out  = {out_valid, taken, mispredict, redirect_idx, squash_mask};
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input vec_t v);
        lane_en = v.en; pred_taken = v.pred; mode = v.md;
        op_a = v.a; op_b = v.b; rt = v.r; in_valid = 1'b1;
    endtask

    task automatic ln(input int k, input int l, input logic [2:0] m,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
        tbl[k].md[l] = m; tbl[k].a[l] = a; tbl[k].b[l] = b; tbl[k].r[l] = r;
    endtask

    task automatic model_reset();
        exp_q.delete();
        cnt_m = 0;
        hold_prev = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        for (int k = 0; k < 8; k++) tbl[k] = '0;
        // lane0 a==b taken, lane1 a!=b not taken vs pred 1 -> redirect at 1
        tbl[0].en = 4'b0011; tbl[0].pred = 4'b0011;
        ln(0, 0, 3'b000, 5, 5, 0); ln(0, 1, 3'b001, 3, 3, 0);
        tbl[0].exp = '{tk: 4'b0001, mp: 1'b1, idx: 2'd1, sq: 4'b1100};
        // signed boundaries
        tbl[1].en = 4'b1111; tbl[1].pred = 4'b1110;
        ln(1, 0, 3'b010, 32'hFFFF_FFFF, 0, 0); ln(1, 1, 3'b100, 32'h8000_0000, 0, 0);
        ln(1, 2, 3'b100, 0, 0, 1);             ln(1, 3, 3'b011, 0, 0, 0);
        tbl[1].exp = '{tk: 4'b1110, mp: 1'b0, idx: 2'd0, sq: 4'b0000};
        // no lanes enabled still flows
        tbl[2].en = 4'b0000; tbl[2].pred = 4'b1111;
        for (int l = 0; l < 4; l++) ln(2, l, 3'b101, 0, 0, 0);
        tbl[2].exp = '{tk: 4'b0000, mp: 1'b0, idx: 2'd0, sq: 4'b0000};
        // all always-taken, predicted not taken -> redirect at 0
        tbl[3].en = 4'b1111; tbl[3].pred = 4'b0000;
        for (int l = 0; l < 4; l++) ln(3, l, 3'b101, 0, 0, 0);
        tbl[3].exp = '{tk: 4'b1111, mp: 1'b1, idx: 2'd0, sq: 4'b1110};
        // top lane only, never-taken mode vs pred 1 -> empty squash
        tbl[4].en = 4'b1000; tbl[4].pred = 4'b1000;
        ln(4, 3, 3'b110, 0, 0, 0);
        tbl[4].exp = '{tk: 4'b0000, mp: 1'b1, idx: 2'd3, sq: 4'b0000};
        // a>0 with a=1, mode 111 never taken
        tbl[5].en = 4'b0101; tbl[5].pred = 4'b0001;
        ln(5, 0, 3'b010, 1, 32'hDEAD, 0); ln(5, 2, 3'b111, 0, 0, 0);
        tbl[5].exp = '{tk: 4'b0001, mp: 1'b0, idx: 2'd0, sq: 4'b0000};
        // mismatch in lane 2
        tbl[6].en = 4'b0100; tbl[6].pred = 4'b0000;
        ln(6, 2, 3'b001, 1, 2, 0);
        tbl[6].exp = '{tk: 4'b0100, mp: 1'b1, idx: 2'd2, sq: 4'b1000};
        // more sign cases
        tbl[7].en = 4'b1111; tbl[7].pred = 4'b0011;
        ln(7, 0, 3'b011, 32'h8000_0000, 0, 0); ln(7, 1, 3'b100, 32'h7FFF_FFFF, 0, 5);
        ln(7, 2, 3'b100, 0, 0, 0);             ln(7, 3, 3'b000, 1, 0, 0);
        tbl[7].exp = '{tk: 4'b0011, mp: 1'b0, idx: 2'd0, sq: 4'b0000};

        // reset state
        #1 resetn = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outputs", {taken, mispredict, redirect_idx, squash_mask}, 0);
        chk("rst_count", mispredict_count, 0);
        chk("rst_in_ready", in_ready, 1);
        #20 resetn = 1'b1;
        @(posedge clk); #1;

        // directed table, out_ready high, 2-cycle latency
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drv(tbl[k]);
            tick();
            in_valid = 1'b0;
            tick();
            chk($sformatf("v%0d_out_valid", k), out_valid, 1);
            chk($sformatf("v%0d_taken", k), taken, tbl[k].exp.tk);
            chk($sformatf("v%0d_mispredict", k), mispredict, tbl[k].exp.mp);
            chk($sformatf("v%0d_redirect_idx", k), redirect_idx, tbl[k].exp.idx);
            chk($sformatf("v%0d_squash_mask", k), squash_mask, tbl[k].exp.sq);
        end
        tick(); tick();

        // back-pressure: three back-to-back bundles, out_ready low three cycles
        begin
            int base;
            base = n_deliv;
            out_ready = 1'b0;
            drv(tbl[0]); tick();
            drv(tbl[3]); tick();
            drv(tbl[6]);
            chk("bp_in_ready_low", in_ready, 0);
            tick();
            chk("bp_in_ready_still_low", in_ready, 0);
            chk("bp_out_held_b1", {taken, mispredict, redirect_idx, squash_mask}, tbl[0].exp);
            out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            repeat (4) tick();
            chk("bp_delivered", n_deliv - base, 3);
            chk("bp_drained", exp_q.size(), 0);
        end

        // flush with both stages full and a new bundle on the input
        begin
            int base;
            out_ready = 1'b0;
            drv(tbl[3]); tick();
            drv(tbl[0]); tick();
            drv(tbl[6]); flush = 1'b1;
            base = n_deliv;
            tick();
            flush = 1'b0; in_valid = 1'b0;
            chk("flush_out_valid", out_valid, 0);
            chk("flush_in_ready", in_ready, 1);
            chk("flush_count", mispredict_count, cnt_m);
            out_ready = 1'b1;
            repeat (3) tick();
            chk("flush_nothing_delivered", n_deliv - base, 0);
            chk("flush_out_valid_after", out_valid, 0);
        end

        // saturation: 20 mispredicted bundles on a 4-bit counter
        #2 resetn = 1'b0;
        model_reset();
        #2 resetn = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drv(tbl[3]);
        repeat (20) tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("sat_count", mispredict_count, 15);

        // async reset while out_valid is high and stalled
        out_ready = 1'b0;
        drv(tbl[0]); tick();
        in_valid = 1'b0; tick();
        chk("ar_pre_out_valid", out_valid, 1);
        #1 resetn = 1'b0;
        model_reset();
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_outputs", {taken, mispredict, redirect_idx, squash_mask}, 0);
        chk("ar_count", mispredict_count, 0);
        resetn = 1'b1;
        #1;
        chk("ar_in_ready", in_ready, 1);
        out_ready = 1'b1;
        drv(tbl[6]); tick();
        in_valid = 1'b0; tick();
        chk("ar_first_accept", out_valid, 1);
        chk("ar_first_taken", taken, tbl[6].exp.tk);
        tick(); tick();

        // random traffic against the scoreboard
        for (int c = 0; c < 500; c++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 9) < 7);
            flush      = ($urandom_range(0, 39) == 0);
            lane_en    = 4'($urandom);
            pred_taken = 4'($urandom);
            mode       = 12'($urandom);
            for (int l = 0; l < LANES; l++) begin
                logic [31:0] a;
                a = pick();
                op_a[l*32 +: 32] = a;
                op_b[l*32 +: 32] = ($urandom_range(0, 1) == 0) ? a : pick();
                rt[l*5 +: 5] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            end
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        chk("rand_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
